// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blink_sequencer
// Purpose  : LED blink sequencer. After an accepted start it produces `reps`
//            ON/OFF pairs whose phase lengths are latched at start, then
//            pulses done for one cycle. abort or reset ends a sequence early
//            without a done pulse.
// Config   : BLINK_REPEAT_FOREVER_EN -- when defined, a start with reps=0
//            blinks indefinitely until abort or reset. When undefined, a
//            start with reps=0 stays idle and pulses done on the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
module blink_sequencer #(
  parameter int CNT_W = 27,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] on_time,
  input  logic [CNT_W-1:0] off_time,
  input  logic [REP_W-1:0] reps,
  output logic             led,
  output logic             busy,
  output logic             done
);

`ifdef BLINK_REPEAT_FOREVER_EN
  localparam bit C_FOREVER_EN = 1'b1;
`else
  localparam bit C_FOREVER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;      // shared phase down-counter
  logic [CNT_W-1:0] on_m1_q;    // latched ON length minus one
  logic [CNT_W-1:0] off_m1_q;   // latched OFF length minus one
  logic [REP_W-1:0] rem_q;      // remaining ON/OFF pairs (0 = forever)
  logic             led_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] w_on_m1_d;
  logic [CNT_W-1:0] w_off_m1_d;
  logic             w_start_ok;

  // Convert the raw phase lengths to counter reload values; a length of 0
  // is treated as 1, so the reload never underflows.
  always_comb begin
    w_on_m1_d  = (on_time  == '0) ? '0 : on_time  - CNT_W'(1);
    w_off_m1_d = (off_time == '0) ? '0 : off_time - CNT_W'(1);
    // The done cycle is an IDLE cycle that must not accept a start.
    w_start_ok = (state_q == S_IDLE) && start && !abort && !done_q;
  end

  // Sequencer FSM with registered led/busy/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      on_m1_q  <= '0;
      off_m1_q <= '0;
      rem_q    <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_start_ok) begin
            on_m1_q  <= w_on_m1_d;
            off_m1_q <= w_off_m1_d;
            if ((reps == '0) && !C_FOREVER_EN) begin
              // Empty sequence: nothing to blink, report completion.
              done_q <= 1'b1;
            end else begin
              rem_q   <= reps;
              cnt_q   <= w_on_m1_d;
              state_q <= S_ON;
              led_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end

        S_ON: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= S_OFF;
            cnt_q   <= off_m1_q;
            led_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_OFF: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            if (rem_q == REP_W'(1)) begin
              state_q <= S_IDLE;
              rem_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // rem_q of 0 only occurs in forever mode and is held there.
              if (rem_q != '0) begin
                rem_q <= rem_q - REP_W'(1);
              end
              state_q <= S_ON;
              cnt_q   <= on_m1_q;
              led_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          rem_q   <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_sequencer
// Purpose  : Self-checking bench for blink_sequencer. Stimulus expands each
//            accepted request into its expected per-cycle {led,busy,done}
//            waveform and feeds a scoreboard; a monitor compares every cycle.
// Config   : honours BLINK_REPEAT_FOREVER_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blink_sequencer;
  localparam int CNT_W = 4;
  localparam int REP_W = 3;

  localparam logic [2:0] E_IDLE = 3'b000;
  localparam logic [2:0] E_ON   = 3'b110;
  localparam logic [2:0] E_OFF  = 3'b010;
  localparam logic [2:0] E_DONE = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] on_time = '0;
  logic [CNT_W-1:0] off_time = '0;
  logic [REP_W-1:0] reps = '0;
  logic             led;
  logic             busy;
  logic             done;

  logic [2:0] sb[$];    // expected {led,busy,done} per upcoming cycle
  logic [2:0] plan[$];  // future waveform of the sequence being modelled
  logic [2:0] cur = E_IDLE;
  bit         mon_en = 1'b0;
  bit         forever_on = 1'b0;
  int         f_on = 1;
  int         f_off = 1;
  int         n_checks = 0;
  int         n_fail = 0;

  blink_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .on_time  (on_time),
    .off_time (off_time),
    .reps     (reps),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic push_period(input int lo, input int lf);
    for (int i = 0; i < lo; i++) plan.push_back(E_ON);
    for (int i = 0; i < lf; i++) plan.push_back(E_OFF);
  endtask

  // One clock cycle of stimulus; the model predicts the outputs after the next edge.
  task automatic step(input logic s, input logic a, input logic [CNT_W-1:0] o,
                      input logic [CNT_W-1:0] f, input logic [REP_W-1:0] r);
    int lo;
    int lf;
    logic [2:0] nxt;
    @(posedge clk);
    #2;
    start = s; abort = a; on_time = o; off_time = f; reps = r;
    lo = (o == 0) ? 1 : int'(o);
    lf = (f == 0) ? 1 : int'(f);
    if (cur[1] && a) begin
      plan.delete();
      forever_on = 1'b0;
    end else if (cur == E_IDLE && s && !a) begin
      if (r == 0) begin
`ifdef BLINK_REPEAT_FOREVER_EN
        forever_on = 1'b1;
        f_on = lo;
        f_off = lf;
`else
        plan.push_back(E_DONE);
`endif
      end else begin
        for (int k = 0; k < int'(r); k++) push_period(lo, lf);
        plan.push_back(E_DONE);
      end
    end
    if (plan.size() == 0 && forever_on) push_period(f_on, f_off);
    nxt = (plan.size() != 0) ? plan.pop_front() : E_IDLE;
    sb.push_back(nxt);
    cur = nxt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, CNT_W'($urandom), CNT_W'($urandom), REP_W'($urandom));
  endtask

  task automatic check_now(input string name, input logic [2:0] exp);
    n_checks++;
    if ({led, busy, done} !== exp) begin
      n_fail++;
      $display("FAIL %s: got {led,busy,done}=%b expected %b at %0t", name, {led, busy, done}, exp, $time);
    end
  endtask

  // Asynchronous reset pulled between clock edges, called 2 time units after an edge.
  task automatic reset_mid();
    #4;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_immediate", E_IDLE);
    mon_en = 1'b0;
    sb.delete();
    plan.delete();
    forever_on = 1'b0;
    cur = E_IDLE;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #6;
    check_now("reset_held", E_IDLE);
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    sb.push_back(E_IDLE);
    mon_en = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard once per cycle.
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #4;
      if (mon_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty: got {led,busy,done}=%b expected an entry at %0t", {led, busy, done}, $time);
        end else begin
          e = sb.pop_front();
          if ({led, busy, done} !== e) begin
            n_fail++;
            $display("FAIL cycle_output: got {led,busy,done}=%b expected %b at %0t", {led, busy, done}, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_now("reset_state", E_IDLE);
    @(posedge clk);
    #6;
    rst_n = 1'b1;
    cur = E_IDLE;
    sb.push_back(E_IDLE);
    mon_en = 1'b1;

    // on=3 off=2 reps=2: led 1-3,6-8; busy 1-10; done 11
    step(1'b1, 1'b0, 4'd3, 4'd2, 3'd2);
    idle(13);
    // zero lengths are treated as one cycle
    step(1'b1, 1'b0, 4'd0, 4'd0, 3'd1);
    idle(5);
    // abort in cycle 7 of an on=5 off=5 reps=3 sequence
    step(1'b1, 1'b0, 4'd5, 4'd5, 3'd3);
    idle(6);
    step(1'b0, 1'b1, 4'd5, 4'd5, 3'd3);
    idle(6);
    // start held high: restart only after the done cycle
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 4'd2, 4'd1, 3'd1);
    idle(4);
    // reps = 0
    step(1'b1, 1'b0, 4'd3, 4'd2, 3'd0);
`ifdef BLINK_REPEAT_FOREVER_EN
    idle(52);
    step(1'b0, 1'b1, 4'd3, 4'd2, 3'd0);
`endif
    idle(5);
    // maximum phase lengths, counter must not wrap
    step(1'b1, 1'b0, 4'd15, 4'd15, 3'd1);
    idle(34);
    // max repeat count
    step(1'b1, 1'b0, 4'd1, 4'd2, 3'd7);
    idle(24);
    // abort wins over start in IDLE
    step(1'b1, 1'b1, 4'd3, 4'd3, 3'd1);
    idle(4);
    // reset mid-ON, then a normal start afterwards
    step(1'b1, 1'b0, 4'd8, 4'd2, 3'd2);
    idle(3);
    reset_mid();
    step(1'b1, 1'b0, 4'd2, 4'd2, 3'd1);
    idle(8);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) == 0, ($urandom % 40) == 0,
           CNT_W'($urandom), CNT_W'($urandom), REP_W'($urandom));
    step(1'b0, 1'b1, 4'd0, 4'd0, 3'd0);
    idle(3);
    @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
